// File: rtl/tta_fetch_queue_if.sv
// Fetch-queue port bundle: memory request/response side, execute redirect and decoder word stream.
// The slave modport is the fetch queue's view; the master modport is the environment's view.
interface tta_fetch_queue_if #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              enable_i;
  logic              redirect_i;
  logic [ADDR_W-1:0] redirect_pc_i;
  logic              ireq_o;
  logic [ADDR_W-1:0] iaddr_o;
  logic              igrant_i;
  logic              irvalid_i;
  logic [WORD_W-1:0] irdata_i;
  logic              word_valid_o;
  logic [WORD_W-1:0] word_o;
  logic [ADDR_W-1:0] word_pc_o;
  logic              word_ready_i;
  logic [CNT_W-1:0]  count_o;
  logic              err_o;

  modport slave (
    input  enable_i, redirect_i, redirect_pc_i, igrant_i, irvalid_i, irdata_i, word_ready_i,
    output ireq_o, iaddr_o, word_valid_o, word_o, word_pc_o, count_o, err_o
  );

  modport master (
    output enable_i, redirect_i, redirect_pc_i, igrant_i, irvalid_i, irdata_i, word_ready_i,
    input  ireq_o, iaddr_o, word_valid_o, word_o, word_pc_o, count_o, err_o
  );
endinterface

// File: rtl/tta_fetch_queue.sv
// Prefetching fetch queue: PC-tagged words land one cycle after their response; the request is gated by
// credit (buffered + in-flight + to-be-dropped < DEPTH), so a stalled consumer stops fetching and never overflows.
module tta_fetch_queue #(
  parameter int                ADDR_W    = 32,
  parameter int                WORD_W    = 32,
  parameter int                DEPTH     = 4,
  parameter int                ADDR_STEP = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input logic            clk_i,
  input logic            rst_i,
  tta_fetch_queue_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);

  typedef struct packed {
    logic [WORD_W-1:0] dat;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  entry_t            mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  occ;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  drop;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] resp_pc;
  logic              err;

  logic [CNT_W+1:0]  credit_used;
  logic [CNT_W:0]    inflight;
  logic [CNT_W-1:0]  redirect_drop;
  logic              grant;
  logic              pop;
  logic              resp_drop;
  logic              resp_take;
  logic              resp_err;

  assign credit_used = (CNT_W+2)'(occ) + (CNT_W+2)'(outstanding) + (CNT_W+2)'(drop);

  assign bus.ireq_o  = bus.enable_i & ~bus.redirect_i & (credit_used < (CNT_W+2)'(DEPTH));
  assign bus.iaddr_o = fetch_pc;

  assign grant     = bus.ireq_o & bus.igrant_i;
  assign pop       = (occ != '0) & bus.word_ready_i & ~bus.redirect_i;
  assign resp_drop = bus.irvalid_i & (drop != '0);
  assign resp_take = bus.irvalid_i & (drop == '0) & (outstanding != '0) & ~bus.redirect_i;
  assign resp_err  = bus.irvalid_i & (drop == '0) & (outstanding == '0);

  // Everything still in flight at a redirect becomes stale, less any response retiring this very cycle.
  assign inflight      = {1'b0, drop} + {1'b0, outstanding};
  assign redirect_drop = CNT_W'(inflight - (CNT_W+1)'(bus.irvalid_i && (inflight != '0)));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      occ         <= '0;
      outstanding <= '0;
      drop        <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      err         <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (resp_err) begin
        err <= 1'b1;
      end
      if (bus.redirect_i) begin
        fetch_pc    <= bus.redirect_pc_i;
        resp_pc     <= bus.redirect_pc_i;
        occ         <= '0;
        rd_ptr      <= '0;
        wr_ptr      <= '0;
        outstanding <= '0;
        drop        <= redirect_drop;
      end else begin
        if (grant) begin
          fetch_pc <= fetch_pc + STEP;
        end
        outstanding <= outstanding + CNT_W'(grant) - CNT_W'(resp_take);
        if (resp_drop) begin
          drop <= drop - CNT_W'(1);
        end
        if (resp_take) begin
          mem[wr_ptr] <= '{dat: bus.irdata_i, pc: resp_pc};
          wr_ptr      <= wr_ptr + PTR_W'(1);
          resp_pc     <= resp_pc + STEP;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        occ <= occ + CNT_W'(resp_take) - CNT_W'(pop);
      end
    end
  end

  assign bus.word_valid_o = (occ != '0);
  assign bus.word_o       = mem[rd_ptr].dat;
  assign bus.word_pc_o    = mem[rd_ptr].pc;
  assign bus.count_o      = occ;
  assign bus.err_o        = err;
endmodule

// File: tb/tb_tta_fetch_queue.sv
// Bench: in-order memory responder with random latency, expected word stream = consecutive PCs since the last redirect.
module tb_tta_fetch_queue;
  localparam int AW = 32;
  localparam int WW = 32;
  localparam int D  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tta_fetch_queue_if #(.ADDR_W(AW), .WORD_W(WW), .DEPTH(D)) bus ();
  tta_fetch_queue_if #(.ADDR_W(AW), .WORD_W(WW), .DEPTH(D)) wbus ();

  tta_fetch_queue #(.ADDR_W(AW), .WORD_W(WW), .DEPTH(D), .ADDR_STEP(4), .RESET_PC(32'h0000_0000)) u_dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  tta_fetch_queue #(.ADDR_W(AW), .WORD_W(WW), .DEPTH(D), .ADDR_STEP(4), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (wbus)
  );

  int          n_vec = 0;
  int          n_mis = 0;
  int          cyc = 0;
  int          n_grant = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  bit          resp_en = 1'b1;
  bit          bogus = 1'b0;
  logic        exp_err = 1'b0;
  logic [31:0] key = 32'h0;
  logic [31:0] exp_pc = 32'h0;
  logic [31:0] pend_addr [$];
  int          pend_due [$];

  logic        prev_hold = 1'b0;
  logic        prev_wait = 1'b0;
  logic [31:0] prev_word, prev_pc, prev_iaddr;

  int          g0, k;
  logic        wv;
  logic [31:0] wa;
  logic [31:0] wexp [3];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: entered and left at a falling edge; caller has set the control inputs.
  task automatic cycle();
    bit g, p, r, redir;
    int occ_plus;
    r = 1'b0;
    if (bogus) begin
      r = 1'b1;
      bus.irdata_i = 32'hDEAD_BEEF;
    end else if (resp_en && pend_addr.size() > 0 && cyc >= pend_due[0]) begin
      r = 1'b1;
      bus.irdata_i = pend_addr[0] ^ key;
    end
    bus.irvalid_i = r;
    #1;
    redir = bus.redirect_i;
    occ_plus = int'(bus.count_o) + pend_addr.size();

    chk("credit_inv", 64'(occ_plus <= D), 64'(1));
    chk("ireq", 64'(bus.ireq_o), 64'(bus.enable_i && !redir && occ_plus < D));
    chk("valid", 64'(bus.word_valid_o), 64'(bus.count_o != 0));
    chk("err", 64'(bus.err_o), 64'(exp_err));
    if (prev_wait && bus.enable_i && !redir) begin
      chk("iaddr_hold", 64'(bus.iaddr_o), 64'(prev_iaddr));
    end
    if (prev_hold) begin
      chk("word_hold", 64'(bus.word_o), 64'(prev_word));
      chk("pc_hold", 64'(bus.word_pc_o), 64'(prev_pc));
    end

    g = bus.ireq_o && bus.igrant_i;
    p = bus.word_valid_o && bus.word_ready_i && !redir;
    if (p) begin
      chk("pop_pc", 64'(bus.word_pc_o), 64'(exp_pc));
      chk("pop_dat", 64'(bus.word_o), 64'(exp_pc ^ key));
      exp_pc = exp_pc + 32'd4;
    end
    if (redir) exp_pc = bus.redirect_pc_i;
    if (r && pend_addr.size() == 0) exp_err = 1'b1;

    prev_hold  = bus.word_valid_o && !bus.word_ready_i && !redir;
    prev_wait  = bus.ireq_o && !bus.igrant_i;
    prev_word  = bus.word_o;
    prev_pc    = bus.word_pc_o;
    prev_iaddr = bus.iaddr_o;

    if (r && !bogus && pend_addr.size() > 0) begin
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    if (g) begin
      pend_addr.push_back(bus.iaddr_o);
      pend_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
      n_grant++;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    bus.enable_i = 0; bus.redirect_i = 0; bus.redirect_pc_i = '0; bus.igrant_i = 0;
    bus.irvalid_i = 0; bus.irdata_i = '0; bus.word_ready_i = 0;
    wbus.enable_i = 0; wbus.redirect_i = 0; wbus.redirect_pc_i = '0; wbus.igrant_i = 0;
    wbus.irvalid_i = 0; wbus.irdata_i = '0; wbus.word_ready_i = 0;
    wexp = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};

    repeat (2) @(negedge clk);
    chk("rst_ireq", 64'(bus.ireq_o), 64'(0));
    chk("rst_iaddr", 64'(bus.iaddr_o), 64'(0));
    chk("rst_valid", 64'(bus.word_valid_o), 64'(0));
    chk("rst_word", 64'(bus.word_o), 64'(0));
    chk("rst_pc", 64'(bus.word_pc_o), 64'(0));
    chk("rst_count", 64'(bus.count_o), 64'(0));
    chk("rst_err", 64'(bus.err_o), 64'(0));
    chk("rst_wrap_iaddr", 64'(wbus.iaddr_o), 64'(32'hFFFF_FFF8));
    rst_n = 1'b1;
    @(negedge clk);

    // Fill with a stalled consumer: exactly DEPTH grants, then fetching stops.
    bus.enable_i = 1; bus.igrant_i = 1; bus.word_ready_i = 0;
    repeat (12) cycle();
    chk("fill_grants", 64'(n_grant), 64'(4));
    chk("fill_ireq", 64'(bus.ireq_o), 64'(0));
    chk("fill_count", 64'(bus.count_o), 64'(4));
    bus.enable_i = 0; bus.word_ready_i = 1;
    repeat (8) cycle();
    chk("fill_drained", 64'(bus.count_o), 64'(0));

    // Grants stall three cycles in four, latency 5.
    key = 32'h5A5A_3C3C;
    lat_min = 5; lat_max = 5;
    bus.enable_i = 1;
    for (int i = 0; i < 40; i++) begin
      bus.igrant_i = (i % 4 == 3);
      cycle();
    end
    bus.enable_i = 0; bus.igrant_i = 1;
    repeat (12) cycle();
    chk("stall_drained", 64'(bus.count_o), 64'(0));

    // Redirect with three requests in flight.
    lat_min = 2; lat_max = 2; resp_en = 0; bus.enable_i = 1;
    for (int i = 0; i < 10 && pend_addr.size() < 3; i++) cycle();
    bus.enable_i = 0;
    chk("redir3_inflight", 64'(pend_addr.size()), 64'(3));
    bus.redirect_i = 1; bus.redirect_pc_i = 32'h100;
    cycle();
    bus.redirect_i = 0; resp_en = 1; bus.enable_i = 1;
    for (int i = 0; i < 30; i++) begin
      if (bus.word_valid_o) break;
      cycle();
    end
    chk("redir3_first_pc", 64'(bus.word_pc_o), 64'(32'h100));
    chk("redir3_err", 64'(bus.err_o), 64'(0));
    bus.enable_i = 0;
    repeat (12) cycle();

    // Redirect coincident with a response and a pop.
    lat_min = 1; lat_max = 1; resp_en = 0; bus.enable_i = 1; bus.word_ready_i = 0;
    for (int i = 0; i < 10 && pend_addr.size() < 4; i++) cycle();
    bus.enable_i = 0; resp_en = 1;
    cycle();
    chk("coinc_pre_count", 64'(bus.count_o), 64'(1));
    bus.redirect_i = 1; bus.redirect_pc_i = 32'h200; bus.word_ready_i = 1;
    cycle();
    bus.redirect_i = 0;
    chk("coinc_count", 64'(bus.count_o), 64'(0));
    chk("coinc_valid", 64'(bus.word_valid_o), 64'(0));
    g0 = n_grant; resp_en = 0; bus.enable_i = 1; bus.word_ready_i = 0;
    repeat (5) cycle();
    chk("coinc_drop_credit", 64'(n_grant - g0), 64'(2));
    bus.enable_i = 0; resp_en = 1; bus.word_ready_i = 1;
    repeat (12) cycle();
    chk("coinc_drained", 64'(bus.count_o), 64'(0));

    // Spurious response with nothing outstanding.
    bus.enable_i = 1; bus.word_ready_i = 0;
    repeat (2) cycle();
    bus.enable_i = 0;
    repeat (4) cycle();
    chk("spur_pre_count", 64'(bus.count_o), 64'(2));
    bogus = 1;
    cycle();
    bogus = 0;
    chk("spur_err", 64'(bus.err_o), 64'(1));
    chk("spur_count", 64'(bus.count_o), 64'(2));
    bus.word_ready_i = 1;
    repeat (4) cycle();
    chk("spur_err_sticky", 64'(bus.err_o), 64'(1));

    // Random soak.
    lat_min = 1; lat_max = 6;
    for (int i = 0; i < 10000; i++) begin
      bus.enable_i      = ($urandom_range(9, 0) != 0);
      bus.igrant_i      = ($urandom_range(2, 0) != 0);
      bus.word_ready_i  = ($urandom_range(3, 0) != 0);
      resp_en           = ($urandom_range(3, 0) != 0);
      bus.redirect_i    = ($urandom_range(39, 0) == 0);
      bus.redirect_pc_i = $urandom() & 32'hFFFF_FFFC;
      cycle();
    end
    bus.redirect_i = 0; bus.enable_i = 0; resp_en = 1; bus.word_ready_i = 1;
    repeat (20) cycle();
    chk("soak_drained", 64'(bus.count_o), 64'(0));

    // PC wrap from RESET_PC = FFFF_FFF8, data = address, latency 1.
    wbus.enable_i = 1; wbus.igrant_i = 1; wbus.word_ready_i = 1;
    wv = 0; wa = '0; k = 0;
    for (int i = 0; i < 12; i++) begin
      wbus.irvalid_i = wv;
      wbus.irdata_i  = wa;
      #1;
      if (wbus.word_valid_o && k < 3) begin
        chk("wrap_pc", 64'(wbus.word_pc_o), 64'(wexp[k]));
        chk("wrap_dat", 64'(wbus.word_o), 64'(wexp[k]));
        k++;
      end
      wv = wbus.ireq_o && wbus.igrant_i;
      wa = wbus.iaddr_o;
      @(posedge clk);
      @(negedge clk);
    end
    chk("wrap_seen", 64'(k), 64'(3));
    chk("wrap_err", 64'(wbus.err_o), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
